// File: rtl/fx1_pipe.sv
// Pipelined FX1 simple-fixed ALU: one op per cycle, LATENCY register stages, stall/flush.
// Optional perf counters via `define FX1_PIPE_PERF_CNT_EN. Spec bit 0 (MSB) is our bit W-1.

package fx1_pipe_pkg;
  localparam logic [6:0] OP_A     = 7'd0,  OP_ADDX  = 7'd1,  OP_AH    = 7'd2,  OP_AHI   = 7'd3;
  localparam logic [6:0] OP_AI    = 7'd4,  OP_AND   = 7'd5,  OP_ANDHI = 7'd6,  OP_ANDI  = 7'd7;
  localparam logic [6:0] OP_BG    = 7'd8,  OP_BGX   = 7'd9,  OP_CEQ   = 7'd10, OP_CEQH  = 7'd11;
  localparam logic [6:0] OP_CEQI  = 7'd12, OP_CEQHI = 7'd13, OP_CG    = 7'd14, OP_CGT   = 7'd15;
  localparam logic [6:0] OP_CGTH  = 7'd16, OP_CGTHI = 7'd17, OP_CGTI  = 7'd18, OP_CGX   = 7'd19;
  localparam logic [6:0] OP_CLZ   = 7'd20, OP_EQV   = 7'd21, OP_IL    = 7'd22, OP_ILA   = 7'd23;
  localparam logic [6:0] OP_ILH   = 7'd24, OP_ILHU  = 7'd25, OP_IOHL  = 7'd26, OP_NAND  = 7'd27;
  localparam logic [6:0] OP_NOR   = 7'd28, OP_OR    = 7'd29, OP_ORHI  = 7'd30, OP_ORI   = 7'd31;
  localparam logic [6:0] OP_SELB  = 7'd32, OP_SF    = 7'd33, OP_SFH   = 7'd34, OP_SFHI  = 7'd35;
  localparam logic [6:0] OP_SFI   = 7'd36, OP_SFX   = 7'd37, OP_XOR   = 7'd38, OP_XORHI = 7'd39;
  localparam logic [6:0] OP_XORI  = 7'd40;
  localparam logic [6:0] OP_LAST  = OP_XORI;
endpackage

// One 32-bit word lane; halfword ops split the word into two 16-bit sub-lanes.
module fx1_word
  import fx1_pipe_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [31:0] ra,
  input  logic [31:0] rb,
  input  logic [31:0] rc,
  input  logic [9:0]  imm10,
  input  logic [15:0] imm16,
  input  logic [17:0] imm18,
  output logic [31:0] res
);
  logic [31:0]      i10w, i10h2, i8b;
  logic [15:0]      i10h;
  logic             cin;
  logic [32:0]      add_c, addx_c, subx_c;
  logic [1:0][15:0] rah, rbh;
  logic [5:0]       lz;

  assign i10w   = {{22{imm10[9]}}, imm10};
  assign i10h   = {{6{imm10[9]}}, imm10};
  assign i10h2  = {i10h, i10h};
  assign i8b    = {4{imm10[7:0]}};
  assign cin    = rc[0];
  assign add_c  = {1'b0, ra} + {1'b0, rb};
  assign addx_c = add_c + {32'b0, cin};
  // rb + ~ra + cin: carry out is the "no borrow" flag for bgx, low word is sfx
  assign subx_c = {1'b0, rb} + {1'b0, ~ra} + {32'b0, cin};
  assign rah    = ra;
  assign rbh    = rb;

  always_comb begin
    lz = 6'd32;
    for (int i = 0; i < 32; i++)
      if (ra[i]) lz = 6'(31 - i);
  end

  function automatic logic [15:0] half_op(input logic [6:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] im);
    logic [15:0] r;
    r = '0;
    case (o)
      OP_AH:    r = a + b;
      OP_AHI:   r = a + im;
      OP_CEQH:  r = {16{a == b}};
      OP_CEQHI: r = {16{a == im}};
      OP_CGTH:  r = {16{$signed(a) > $signed(b)}};
      OP_CGTHI: r = {16{$signed(a) > $signed(im)}};
      OP_SFH:   r = b - a;
      OP_SFHI:  r = im - a;
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    res = '0;
    case (op)
      OP_A:     res = add_c[31:0];
      OP_ADDX:  res = addx_c[31:0];
      OP_AI:    res = ra + i10w;
      OP_AND:   res = ra & rb;
      OP_ANDHI: res = ra & i10h2;
      OP_ANDI:  res = ra & i8b;
      OP_BG:    res = {31'b0, ra <= rb};
      OP_BGX:   res = {31'b0, subx_c[32]};
      OP_CEQ:   res = {32{ra == rb}};
      OP_CEQI:  res = {32{ra == i10w}};
      OP_CG:    res = {31'b0, add_c[32]};
      OP_CGT:   res = {32{$signed(ra) > $signed(rb)}};
      OP_CGTI:  res = {32{$signed(ra) > $signed(i10w)}};
      OP_CGX:   res = {31'b0, addx_c[32]};
      OP_CLZ:   res = {26'b0, lz};
      OP_EQV:   res = ~(ra ^ rb);
      OP_IL:    res = {{16{imm16[15]}}, imm16};
      OP_ILA:   res = {14'b0, imm18};
      OP_ILH:   res = {imm16, imm16};
      OP_ILHU:  res = {imm16, 16'b0};
      OP_IOHL:  res = rc | {16'b0, imm16};
      OP_NAND:  res = ~(ra & rb);
      OP_NOR:   res = ~(ra | rb);
      OP_OR:    res = ra | rb;
      OP_ORHI:  res = ra | i10h2;
      OP_ORI:   res = ra | i8b;
      OP_SELB:  res = (rc & rb) | (~rc & ra);
      OP_SF:    res = rb - ra;
      OP_SFI:   res = i10w - ra;
      OP_SFX:   res = subx_c[31:0];
      OP_XOR:   res = ra ^ rb;
      OP_XORHI: res = ra ^ i10h2;
      OP_XORI:  res = ra ^ i8b;
      OP_AH, OP_AHI, OP_CEQH, OP_CEQHI, OP_CGTH, OP_CGTHI, OP_SFH, OP_SFHI:
        for (int h = 0; h < 2; h++)
          res[16*h +: 16] = half_op(op, rah[h], rbh[h], i10h);
      default:  res = '0;
    endcase
  end
endmodule

module fx1_pipe
  import fx1_pipe_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int LATENCY = 2,
  parameter int RT_W    = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [6:0]                instr_id,
  input  logic [DATA_W-1:0]         ra_data,
  input  logic [DATA_W-1:0]         rb_data,
  input  logic [DATA_W-1:0]         rc_data,
  input  logic [9:0]                imme10,
  input  logic [15:0]               imme16,
  input  logic [17:0]               imme18,
  input  logic [RT_W-1:0]           rt_addr,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_result,
  output logic [RT_W-1:0]           out_rt_addr,
  output logic                      out_illegal,
  output logic [LATENCY-1:0]        stage_valid,
  output logic [LATENCY*RT_W-1:0]   stage_rt_addr,
  output logic [LATENCY*DATA_W-1:0] stage_result
`ifdef FX1_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]               perf_retired,
  output logic [31:0]               perf_illegal
`endif
);
  localparam int NUM_LANES = DATA_W / 32;

  typedef struct packed {
    logic              ill;
    logic [RT_W-1:0]   rt;
    logic [DATA_W-1:0] res;
  } stage_t;

  logic [DATA_W-1:0]  res_c;
  logic               ill_c;
  logic [LATENCY:1]   vld_pipe;
  stage_t [LATENCY:1] stg_q;

  // Lane 0 is the most significant word of each data vector
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int LO = DATA_W - 32*(l+1);
    fx1_word u_word (
      .op    (instr_id),
      .ra    (ra_data[LO +: 32]),
      .rb    (rb_data[LO +: 32]),
      .rc    (rc_data[LO +: 32]),
      .imm10 (imme10),
      .imm16 (imme16),
      .imm18 (imme18),
      .res   (res_c[LO +: 32])
    );
  end

  assign ill_c = instr_id > OP_LAST;

  // Flush only clears valids; stage data may stay stale
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      stg_q    <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (!stall) begin
      vld_pipe[1]   <= issue_valid;
      stg_q[1].ill  <= issue_valid & ill_c;
      stg_q[1].rt   <= rt_addr;
      stg_q[1].res  <= res_c;
      for (int k = 2; k <= LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        stg_q[k]    <= stg_q[k-1];
      end
    end
  end

  assign out_valid   = vld_pipe[LATENCY];
  assign out_result  = stg_q[LATENCY].res;
  assign out_rt_addr = stg_q[LATENCY].rt;
  assign out_illegal = vld_pipe[LATENCY] & stg_q[LATENCY].ill;

  for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
    assign stage_valid[k-1]                           = vld_pipe[k];
    assign stage_rt_addr[(LATENCY-k)*RT_W +: RT_W]    = stg_q[k].rt;
    assign stage_result[(LATENCY-k)*DATA_W +: DATA_W] = stg_q[k].res;
  end

`ifdef FX1_PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_illegal <= '0;
    end else if (out_valid && !stall) begin
      perf_retired <= perf_retired + 32'd1;
      if (out_illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fx1_pipe.sv
// Self-checking bench for fx1_pipe: directed test-plan cases plus random traffic
// against an age-tracking queue model with a word/halfword arithmetic reference.
module tb_fx1_pipe;
  import fx1_pipe_pkg::*;

  localparam int DW  = 128;
  localparam int LAT = 2;
  localparam int RW  = 7;
  localparam int NW  = DW / 32;

  logic              clk = 1'b0;
  logic              rst, issue_valid, stall, flush;
  logic [6:0]        instr_id;
  logic [DW-1:0]     ra_data, rb_data, rc_data;
  logic [9:0]        imme10;
  logic [15:0]       imme16;
  logic [17:0]       imme18;
  logic [RW-1:0]     rt_addr;
  logic              out_valid, out_illegal;
  logic [DW-1:0]     out_result;
  logic [RW-1:0]     out_rt_addr;
  logic [LAT-1:0]    stage_valid;
  logic [LAT*RW-1:0] stage_rt_addr;
  logic [LAT*DW-1:0] stage_result;
`ifdef FX1_PIPE_PERF_CNT_EN
  logic [31:0]       perf_retired, perf_illegal;
  logic [31:0]       m_ret = 0, m_ill = 0;
`endif

  fx1_pipe #(.DATA_W(DW), .LATENCY(LAT), .RT_W(RW)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .instr_id(instr_id),
    .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data),
    .imme10(imme10), .imme16(imme16), .imme18(imme18), .rt_addr(rt_addr),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_rt_addr(out_rt_addr),
    .out_illegal(out_illegal), .stage_valid(stage_valid),
    .stage_rt_addr(stage_rt_addr), .stage_result(stage_result)
`ifdef FX1_PIPE_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference ----------------
  function automatic logic [15:0] ref_half(input logic [6:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] im);
    case (op)
      OP_AH:    return a + b;
      OP_AHI:   return a + im;
      OP_CEQH:  return (a == b) ? 16'hFFFF : 16'h0;
      OP_CEQHI: return (a == im) ? 16'hFFFF : 16'h0;
      OP_CGTH:  return ($signed(a) > $signed(b)) ? 16'hFFFF : 16'h0;
      OP_CGTHI: return ($signed(a) > $signed(im)) ? 16'hFFFF : 16'h0;
      OP_SFH:   return b - a;
      OP_SFHI:  return im - a;
      default:  return 16'h0;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_exec(input logic [6:0] op, input logic [DW-1:0] ra,
      input logic [DW-1:0] rb, input logic [DW-1:0] rc, input logic [9:0] i10,
      input logic [15:0] i16, input logic [17:0] i18);
    logic [DW-1:0] r;
    logic [31:0]   a, b, c, y, ones, bm;
    logic [15:0]   h10;
    int            s10;
    r    = '0;
    s10  = $signed(i10);
    h10  = 16'(s10);
    ones = 32'hFFFF_FFFF;
    bm   = {4{i10[7:0]}};
    for (int w = 0; w < NW; w++) begin
      a = ra[DW-1-32*w -: 32];
      b = rb[DW-1-32*w -: 32];
      c = rc[DW-1-32*w -: 32];
      y = '0;
      case (op)
        OP_A:     y = a + b;
        OP_ADDX:  y = a + b + {31'b0, c[0]};
        OP_AI:    y = a + s10;
        OP_AND:   y = a & b;
        OP_ANDHI: y = a & {h10, h10};
        OP_ANDI:  y = a & bm;
        OP_BG:    y = {31'b0, b >= a};
        OP_BGX:   y = {31'b0, c[0] ? (b >= a) : (b > a)};
        OP_CEQ:   y = (a == b) ? ones : 32'h0;
        OP_CEQI:  y = ($signed(a) == s10) ? ones : 32'h0;
        OP_CG:    y = 32'((64'(a) + 64'(b)) >> 32);
        OP_CGT:   y = ($signed(a) > $signed(b)) ? ones : 32'h0;
        OP_CGTI:  y = ($signed(a) > s10) ? ones : 32'h0;
        OP_CGX:   y = 32'((64'(a) + 64'(b) + 64'(c[0])) >> 32);
        OP_CLZ: begin
          y = 32;
          for (int i = 31; i >= 0; i--) if (a[i]) begin y = 31 - i; break; end
        end
        OP_EQV:   y = ~(a ^ b);
        OP_IL:    y = 32'($signed(i16));
        OP_ILA:   y = 32'(i18);
        OP_ILH:   y = {i16, i16};
        OP_ILHU:  y = {i16, 16'h0};
        OP_IOHL:  y = c | 32'(i16);
        OP_NAND:  y = ~(a & b);
        OP_NOR:   y = ~(a | b);
        OP_OR:    y = a | b;
        OP_ORHI:  y = a | {h10, h10};
        OP_ORI:   y = a | bm;
        OP_SELB:  y = (b & c) | (a & ~c);
        OP_SF:    y = b - a;
        OP_SFI:   y = s10 - a;
        OP_SFX:   y = b - a - {31'b0, ~c[0]};
        OP_XOR:   y = a ^ b;
        OP_XORHI: y = a ^ {h10, h10};
        OP_XORI:  y = a ^ bm;
        OP_AH, OP_AHI, OP_CEQH, OP_CEQHI, OP_CGTH, OP_CGTHI, OP_SFH, OP_SFHI:
          for (int h = 0; h < 2; h++)
            y[31-16*h -: 16] = ref_half(op, a[31-16*h -: 16], b[31-16*h -: 16], h10);
        default:  y = '0;
      endcase
      r[DW-1-32*w -: 32] = y;
    end
    return r;
  endfunction

  // ---------------- pipeline model: in-flight entries tagged with their stage ----------------
  typedef struct {
    logic [DW-1:0] res;
    logic [RW-1:0] rt;
    bit            ill;
    int            age;
  } ent_t;
  ent_t q[$];

  function automatic int find_age(input int k);
    foreach (q[i]) if (q[i].age == k) return i;
    return -1;
  endfunction

  task automatic update_model();
    int o;
    ent_t e;
    o = find_age(LAT);
`ifdef FX1_PIPE_PERF_CNT_EN
    if (rst) begin m_ret = 0; m_ill = 0; end
    else if (!stall && o >= 0) begin m_ret++; if (q[o].ill) m_ill++; end
`endif
    if (rst || flush) q.delete();
    else if (!stall) begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[0].age > LAT) void'(q.pop_front());
      if (issue_valid) begin
        e.res = ref_exec(instr_id, ra_data, rb_data, rc_data, imme10, imme16, imme18);
        e.rt  = rt_addr;
        e.ill = (instr_id > 7'd40);
        e.age = 1;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    logic [LAT-1:0] ev;
    int idx;
    ev = '0;
    for (int k = 1; k <= LAT; k++) begin
      idx = find_age(k);
      if (idx >= 0) begin
        ev[k-1] = 1'b1;
        chk("stage_rt", stage_rt_addr[(LAT-k)*RW +: RW], q[idx].rt);
        chk("stage_result", stage_result[(LAT-k)*DW +: DW], q[idx].res);
      end
    end
    chk("stage_valid", stage_valid, ev);
    chk("out_valid", out_valid, ev[LAT-1]);
    idx = find_age(LAT);
    if (idx >= 0) begin
      chk("out_result", out_result, q[idx].res);
      chk("out_rt_addr", out_rt_addr, q[idx].rt);
      chk("out_illegal", out_illegal, q[idx].ill);
    end
`ifdef FX1_PIPE_PERF_CNT_EN
    chk("perf_retired", perf_retired, m_ret);
    chk("perf_illegal", perf_illegal, m_ill);
`endif
  endtask

  // One clock: check state mid-cycle, then let the edge and the model advance together
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; issue_valid = 0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [9:0] i10, input logic [RW-1:0] rt);
    idle();
    issue_valid = 1; instr_id = op; ra_data = a; rb_data = b; rc_data = '0;
    imme10 = i10; imme16 = '0; imme18 = '0; rt_addr = rt;
  endtask

  logic [DW-1:0] v;

  initial begin
    idle();
    rst = 1; instr_id = '0; ra_data = '0; rb_data = '0; rc_data = '0;
    imme10 = '0; imme16 = '0; imme18 = '0; rt_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_stage_rt", stage_rt_addr, 0);
    idle();
    tick();

    // word add wraps into the sign bit
    issue(OP_A, {NW{32'h7FFF_FFFF}}, {NW{32'h0000_0001}}, '0, 7'd5);
    tick(); idle(); tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, {NW{32'h8000_0000}});
    chk("t1_rt", out_rt_addr, 5);

    // back-to-back ceqi then clz
    v = '0; v[DW-1 -: 32] = 32'hFFFF_FFFF;
    issue(OP_CEQI, v, '0, 10'h3FF, 7'd1);
    tick();
    v = '0; v[DW-1 -: 32] = 32'h0001_0000;
    issue(OP_CLZ, v, '0, '0, 7'd2);
    tick(); idle();
    v = '0; v[DW-1 -: 32] = 32'hFFFF_FFFF;
    chk("t2_ceqi", out_result, v);
    tick();
    chk("t2_clz_w0", out_result[DW-1 -: 32], 32'd15);
    chk("t2_clz_w1", out_result[DW-33 -: 32], 32'd32);
    tick();

    // stall holds the stage for three cycles
    issue(OP_A, {NW{32'd1}}, {NW{32'd2}}, '0, 7'd3);
    tick(); idle(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", stage_result[(LAT-1)*DW +: DW], {NW{32'd3}});
      chk("t3_no_out", out_valid, 0);
    end
    stall = 0;
    tick();
    chk("t3_valid", out_valid, 1);
    chk("t3_result", out_result, {NW{32'd3}});
    tick();

    // flush with stall, both stages full, plus a dropped issue
    issue(OP_OR, {NW{32'hA}}, {NW{32'h5}}, '0, 7'd7);
    tick();
    issue(OP_XOR, {NW{32'hA}}, {NW{32'h5}}, '0, 7'd8);
    tick();
    issue(OP_AND, {NW{32'hA}}, {NW{32'h5}}, '0, 7'd9);
    flush = 1; stall = 1;
    tick(); idle();
    chk("t4_stage_valid", stage_valid, 0);
    for (int i = 0; i < 3; i++) begin tick(); chk("t4_no_out", out_valid, 0); end

    // unsupported opcode travels with result 0 and the illegal flag
    issue(7'd100, {NW{32'h1234_5678}}, {NW{32'h1}}, '0, 7'd9);
    tick(); idle(); tick();
    chk("t5_valid", out_valid, 1);
    chk("t5_illegal", out_illegal, 1);
    chk("t5_result", out_result, 0);
`ifdef FX1_PIPE_PERF_CNT_EN
    chk("t5_perf_before", perf_illegal, 0);
    tick();
    chk("t5_perf_after", perf_illegal, 1);
`else
    tick();
`endif

    // reset with two instructions in flight
    issue(OP_A, {NW{32'd4}}, {NW{32'd4}}, '0, 7'd11);
    tick();
    issue(OP_SF, {NW{32'd4}}, {NW{32'd9}}, '0, 7'd12);
    tick(); idle(); rst = 1;
    tick(); idle();
    chk("t6_valid", out_valid, 0);
    chk("t6_result", out_result, 0);
    chk("t6_rt", out_rt_addr, 0);
    chk("t6_illegal", out_illegal, 0);
    chk("t6_stage_valid", stage_valid, 0);
    chk("t6_stage_rt", stage_rt_addr, 0);
    chk("t6_stage_result", stage_result, 0);
    for (int i = 0; i < 2; i++) begin tick(); chk("t6_no_out", out_valid, 0); end

    // halfword add wraps per halfword lane
    issue(OP_AH, {2*NW{16'hFFFF}}, {2*NW{16'h0002}}, '0, 7'd13);
    tick(); idle(); tick();
    chk("t7_ah", out_result, {2*NW{16'h0001}});

    // random traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst         = ($urandom_range(0, 99) < 2);
      flush       = ($urandom_range(0, 99) < 5);
      stall       = ($urandom_range(0, 99) < 15);
      issue_valid = ($urandom_range(0, 99) < 80);
      instr_id    = 7'($urandom_range(0, 47));
      for (int w = 0; w < NW; w++) begin
        ra_data[32*w +: 32] = $urandom;
        rb_data[32*w +: 32] = $urandom;
        rc_data[32*w +: 32] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) rb_data = ra_data;
      imme10  = 10'($urandom);
      imme16  = 16'($urandom);
      imme18  = 18'($urandom);
      rt_addr = 7'($urandom);
      tick();
    end
    idle();
    repeat (LAT + 2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
